cnt_down_timer: RTL
===================

// Module: cnt_down_timer
// PURPOSE
//   Loadable down-counter timer; the consuming counterpart of the free-running up counter (CNT).
//   A controller loads a count, starts the timer and waits for a one-cycle done pulse after
//   that many enabled clock cycles. Supports pause, abort and periodic auto-reload.
//   Used as the delay/timeout element next to the lab counter blocks.
// PARAMETERS
//   WIDTH   4   bit width of load_val / cnt_val (max count 2**WIDTH-1)
// PORTS
//   clk       in   1      system clock, all state updates on rising edge
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      begin countdown from load_val (accepted only in IDLE)
//   load_val  in   WIDTH  initial count N, sampled on the edge that accepts start
//   pause     in   1      freeze count while high (RUN only)
//   stop      in   1      abort: return to IDLE, no done pulse
//   cnt_val   out  WIDTH  current count (registered)
//   busy      out  1      high while state == RUN
//   done      out  1      one-cycle pulse on expiry
// BEHAVIOUR
//   Interface: one clock, clk; reset rst is asynchronous and active-high.
//   Reset (async, immediate): state=IDLE, cnt_val=0, busy=0, done=0, reload register=0.
//   All outputs registered; no combinational path from inputs to outputs.
//   States: IDLE, RUN, DONE (2-bit encoding, illegal code -> IDLE).
//   Priority per edge: stop > start > pause > decrement.
//   IDLE: start=1 & N>0 -> RUN, cnt_val=N; start=1 & N==0 -> DONE, cnt_val=0;
//     else hold, cnt_val holds last value.
//   RUN: pause=1 -> hold cnt_val; else cnt_val-1; when cnt_val==1 and not paused ->
//     cnt_val=0, state DONE. Start is ignored in RUN.
//   DONE: done=1 for exactly this one cycle; next edge -> IDLE unconditionally
//     (start in DONE ignored).
//   stop=1 in RUN or DONE -> IDLE next edge, cnt_val=0, done stays/forced 0.
//     stop in IDLE -> no effect (also wins over start: stays IDLE).
//   Latency: done rises N edges after the edge sampling start (N=0 -> 0 edges, i.e. after
//     that same edge), plus one edge per cycle paused in RUN.
//   busy = (state==RUN); done = (state==DONE). cnt_val never wraps below 0.
//   Arithmetic: unsigned WIDTH bits; decrement only when cnt_val>=1.
// CONFIGURATION
//   TIMER_RELOAD_EN defined: load_val latched into reload register at start. In RUN, when
//     cnt_val==1 and not paused, cnt_val <- reload value, done pulses one cycle,
//     state stays RUN (periodic, period N cycles) until stop. N==0 behaves as one-shot.
//     done comes from a dedicated register in this mode.
//   TIMER_RELOAD_EN undefined: one-shot only, reload register and logic absent.
// TESTING
//   rst, start with N=5 -> cnt_val 5,4,3,2,1,0 on successive edges; done high 1 cycle
//     at edge 5; busy high edges 0..4; back to IDLE at edge 6.
//   N=5, pause high for 2 cycles at cnt_val=3 -> cnt_val holds 3 twice; done at edge 7.
//   N=9, stop at cnt_val=4 -> cnt_val=0, IDLE next edge, done never asserts.
//   start with N=0 -> DONE immediately (done after start edge), busy never high.
//   start pulsed again while busy (N=6) and in DONE -> ignored, load_val change not seen;
//     start+stop together in IDLE -> stays IDLE.
//   async rst mid-RUN (cnt_val=2) -> outputs clear without a clock edge;
//     with TIMER_RELOAD_EN, N=3 -> done every 3 cycles until stop.

Source files
------------

// File: rtl/cnt_down_timer.sv
// Loadable down-counter timer with pause, abort and one-cycle done pulse.
// Define TIMER_RELOAD_EN for periodic auto-reload; default build is one-shot.
module cnt_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] cnt_val,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
    logic             busy_r, done_r;
    logic             reload_hit_s;
`ifdef TIMER_RELOAD_EN
    logic [WIDTH-1:0] reload_r, reload_nxt_s;
`endif

    // Next-state and next-count decode; stop > start > pause > decrement
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        reload_hit_s = 1'b0;
`ifdef TIMER_RELOAD_EN
        reload_nxt_s = reload_r;
`endif
        case (state_r)
            IDLE: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                end else if (start) begin
`ifdef TIMER_RELOAD_EN
                    reload_nxt_s = load_val;
`endif
                    if (load_val != ZERO_C) begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = load_val;
                    end else begin
                        state_nxt_s = DONE;
                        cnt_nxt_s   = ZERO_C;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = ZERO_C;
                end else if (pause) begin
                    cnt_nxt_s = cnt_r;
                end else if (cnt_r == ONE_C) begin
`ifdef TIMER_RELOAD_EN
                    cnt_nxt_s    = reload_r;
                    reload_hit_s = 1'b1;
`else
                    cnt_nxt_s   = ZERO_C;
                    state_nxt_s = DONE;
`endif
                end else if (cnt_r != ZERO_C) begin
                    cnt_nxt_s = cnt_r - ONE_C;
                end else begin
                    // a zero count in RUN is unreachable; recover to IDLE
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = ZERO_C;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                if (stop) begin
                    cnt_nxt_s = ZERO_C;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = ZERO_C;
            end
        endcase
    end

    // State, count and output registers; busy/done registered from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= ZERO_C;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE) | reload_hit_s;
        end
    end

`ifdef TIMER_RELOAD_EN
    // Period register captured when a start is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_r <= ZERO_C;
        end else begin
            reload_r <= reload_nxt_s;
        end
    end
`endif

    assign cnt_val = cnt_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
